// File: rtl/axil_split2_if.sv
// axil_split2_if -- AXI4-Lite bundle used on every port of axil_split2.
//
// Signals (all channels): aw{addr,prot,valid,ready}, w{data,strb,valid,ready},
// b{resp,valid,ready}, ar{addr,prot,valid,ready}, r{data,resp,valid,ready}.
// Modports:
//   master -- drives addresses, write data, valids and bready/rready
//   slave  -- drives awready/wready/arready and the b/r response channels
interface axil_split2_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_split2.sv
// axil_split2 -- 1-to-2 AXI4-Lite address splitter (CPU -> RAM / peripherals).
//
// Ports:
//   clk     -- single clock, rising edge
//   rst     -- synchronous active-high reset
//   s_axil  -- upstream slave port (from the CPU core)
//   m0_axil -- downstream master port to the RAM region (M0_BASE/M0_MASK)
//   m1_axil -- downstream master port to the peripheral region (M1_BASE/M1_MASK)
//
// Independent write and read FSMs, each with one transaction in flight.
// M0 wins when an address hits both regions.
//
// Optional feature macro: AXIL_SPLIT_DECERR_EN
//   defined   -- unmapped addresses get a DECERR (2'b11) response, no master access
//   undefined -- unmapped addresses are routed to M0
module axil_split2 #(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] M0_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] M0_MASK    = 32'hFFFC_0000,
  parameter logic [ADDR_WIDTH-1:0] M1_BASE    = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] M1_MASK    = 32'hF000_0000
) (
  input  logic           clk,
  input  logic           rst,
  axil_split2_if.slave   s_axil,
  axil_split2_if.master  m0_axil,
  axil_split2_if.master  m1_axil
);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a,
                               input logic [ADDR_WIDTH-1:0] base,
                               input logic [ADDR_WIDTH-1:0] mask);
    return (a & mask) == (base & mask);
  endfunction

  // Returns {unmapped, select_m1}.
  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic h0;
    logic h1;
    h0 = hit(a, M0_BASE, M0_MASK);
    h1 = hit(a, M1_BASE, M1_MASK);
`ifdef AXIL_SPLIT_DECERR_EN
    return {~h0 & ~h1, ~h0 & h1};
`else
    return {1'b0, ~h0 & h1};
`endif
  endfunction

  // Every output is forced to zero while rst is high, including the
  // cycle before the first reset edge has cleared the registers.
  logic run;
  assign run = ~rst;

  // ---------------------------------------------------------------- write path
  w_state_t              w_state, w_next;
  logic [1:0]            w_dec;
  logic                  w_acc, m_aw_vld, m_w_vld, m_b_rdy;
  logic                  w_sel, aw_pend, w_pend, b_vld;
  logic [1:0]            b_resp;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  sel_awready, sel_wready, sel_bvalid;
  logic [1:0]            sel_bresp;

  assign w_dec       = decode(s_axil.awaddr);
  assign sel_awready = w_sel ? m1_axil.awready : m0_axil.awready;
  assign sel_wready  = w_sel ? m1_axil.wready  : m0_axil.wready;
  assign sel_bvalid  = w_sel ? m1_axil.bvalid  : m0_axil.bvalid;
  assign sel_bresp   = w_sel ? m1_axil.bresp   : m0_axil.bresp;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next   = w_state;
    w_acc    = 1'b0;
    m_aw_vld = 1'b0;
    m_w_vld  = 1'b0;
    m_b_rdy  = 1'b0;
    case (w_state)
      W_IDLE: begin
        // Address and data are taken together so the forwarded pair is complete.
        if (s_axil.awvalid && s_axil.wvalid) begin
          w_acc  = 1'b1;
          w_next = w_dec[1] ? W_ERR : W_FWD;
        end
      end
      W_FWD: begin
        m_aw_vld = aw_pend;
        m_w_vld  = w_pend;
        if ((!aw_pend || sel_awready) && (!w_pend || sel_wready)) w_next = W_RESP;
      end
      W_RESP: begin
        // Stop accepting from the master once a response is parked upstream.
        m_b_rdy = ~b_vld;
        if (b_vld && s_axil.bready) w_next = W_IDLE;
      end
      W_ERR: begin
        if (b_vld && s_axil.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_sel   <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      b_vld   <= 1'b0;
      b_resp  <= 2'b00;
      aw_addr <= '0;
      aw_prot <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (w_acc) begin
        aw_addr <= s_axil.awaddr;
        aw_prot <= s_axil.awprot;
        w_data  <= s_axil.wdata;
        w_strb  <= s_axil.wstrb;
        w_sel   <= w_dec[0];
        aw_pend <= ~w_dec[1];
        w_pend  <= ~w_dec[1];
        if (w_dec[1]) begin
          b_vld  <= 1'b1;
          b_resp <= 2'b11;
        end
      end
      if (m_aw_vld && sel_awready) aw_pend <= 1'b0;
      if (m_w_vld && sel_wready)   w_pend  <= 1'b0;
      if (m_b_rdy && sel_bvalid) begin
        b_vld  <= 1'b1;
        b_resp <= sel_bresp;
      end
      if (b_vld && s_axil.bready) b_vld <= 1'b0;
    end
  end

  assign s_axil.awready  = run & w_acc;
  assign s_axil.wready   = run & w_acc;
  assign s_axil.bvalid   = run & b_vld;
  assign s_axil.bresp    = run ? b_resp : 2'b00;

  assign m0_axil.awvalid = run & m_aw_vld & ~w_sel;
  assign m1_axil.awvalid = run & m_aw_vld &  w_sel;
  assign m0_axil.wvalid  = run & m_w_vld  & ~w_sel;
  assign m1_axil.wvalid  = run & m_w_vld  &  w_sel;
  assign m0_axil.bready  = run & m_b_rdy  & ~w_sel;
  assign m1_axil.bready  = run & m_b_rdy  &  w_sel;
  assign m0_axil.awaddr  = run ? aw_addr : '0;
  assign m1_axil.awaddr  = run ? aw_addr : '0;
  assign m0_axil.awprot  = run ? aw_prot : '0;
  assign m1_axil.awprot  = run ? aw_prot : '0;
  assign m0_axil.wdata   = run ? w_data  : '0;
  assign m1_axil.wdata   = run ? w_data  : '0;
  assign m0_axil.wstrb   = run ? w_strb  : '0;
  assign m1_axil.wstrb   = run ? w_strb  : '0;

  // ----------------------------------------------------------------- read path
  r_state_t              r_state, r_next;
  logic [1:0]            r_dec;
  logic                  r_acc, m_ar_vld, m_r_rdy;
  logic                  r_sel, r_vld;
  logic [1:0]            r_resp;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  sel_arready, sel_rvalid;
  logic [1:0]            sel_rresp;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign r_dec       = decode(s_axil.araddr);
  assign sel_arready = r_sel ? m1_axil.arready : m0_axil.arready;
  assign sel_rvalid  = r_sel ? m1_axil.rvalid  : m0_axil.rvalid;
  assign sel_rresp   = r_sel ? m1_axil.rresp   : m0_axil.rresp;
  assign sel_rdata   = r_sel ? m1_axil.rdata   : m0_axil.rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next   = r_state;
    r_acc    = 1'b0;
    m_ar_vld = 1'b0;
    m_r_rdy  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s_axil.arvalid) begin
          r_acc  = 1'b1;
          r_next = r_dec[1] ? R_ERR : R_ADDR;
        end
      end
      R_ADDR: begin
        m_ar_vld = 1'b1;
        if (sel_arready) r_next = R_DATA;
      end
      R_DATA: begin
        m_r_rdy = ~r_vld;
        if (r_vld && s_axil.rready) r_next = R_IDLE;
      end
      R_ERR: begin
        if (r_vld && s_axil.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= 1'b0;
      r_vld   <= 1'b0;
      r_resp  <= 2'b00;
      r_data  <= '0;
      ar_addr <= '0;
      ar_prot <= '0;
    end else begin
      if (r_acc) begin
        ar_addr <= s_axil.araddr;
        ar_prot <= s_axil.arprot;
        r_sel   <= r_dec[0];
        if (r_dec[1]) begin
          r_vld  <= 1'b1;
          r_resp <= 2'b11;
          r_data <= '0;
        end
      end
      if (m_r_rdy && sel_rvalid) begin
        r_vld  <= 1'b1;
        r_resp <= sel_rresp;
        r_data <= sel_rdata;
      end
      if (r_vld && s_axil.rready) r_vld <= 1'b0;
    end
  end

  assign s_axil.arready  = run & r_acc;
  assign s_axil.rvalid   = run & r_vld;
  assign s_axil.rresp    = run ? r_resp : 2'b00;
  assign s_axil.rdata    = run ? r_data : '0;

  assign m0_axil.arvalid = run & m_ar_vld & ~r_sel;
  assign m1_axil.arvalid = run & m_ar_vld &  r_sel;
  assign m0_axil.rready  = run & m_r_rdy  & ~r_sel;
  assign m1_axil.rready  = run & m_r_rdy  &  r_sel;
  assign m0_axil.araddr  = run ? ar_addr : '0;
  assign m1_axil.araddr  = run ? ar_addr : '0;
  assign m0_axil.arprot  = run ? ar_prot : '0;
  assign m1_axil.arprot  = run ? ar_prot : '0;
endmodule

// File: doc/axil_split2.md
AXIL_SPLIT2 -- requirements
Module: axil_split2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: AXI4-Lite data width on all ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width on all ports.
REQ-003 SHALL have parameter M0_BASE, default 32'h0000_0000: RAM region base.
REQ-004 SHALL have parameter M0_MASK, default 32'hFFFC_0000: RAM region compare mask (256KB).
REQ-005 SHALL have parameter M1_BASE, default 32'h4000_0000: peripheral region base.
REQ-006 SHALL have parameter M1_MASK, default 32'hF000_0000: peripheral region compare mask.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-009 SHALL have port group s_axil_*, slave, full AXI4-Lite (aw/w/b/ar/r; awprot/arprot 3, strb DATA_WIDTH/8, resp 2): upstream from the CPU core.
REQ-010 SHALL have port group m0_axil_*, master, same signal set and widths: downstream to the RAM.
REQ-011 SHALL have port group m1_axil_*, master, same signal set and widths: downstream to the peripheral bus.

Function
REQ-012 Region hit SHALL be (addr & Mx_MASK) == (Mx_BASE & Mx_MASK); M0 SHALL win if both hit.
REQ-013 Write and read paths SHALL be independent FSMs, each with at most one outstanding transaction.
REQ-014 Write FSM states SHALL be W_IDLE, W_FWD, W_RESP, W_ERR.
REQ-015 In W_IDLE, s_awready and s_wready SHALL both assert only when s_awvalid and s_wvalid are both high; addr/prot/data/strb are captured and the FSM moves to W_FWD (mapped) or W_ERR (unmapped).
REQ-016 In W_FWD, the selected master's awvalid and wvalid SHALL assert the cycle after capture and each SHALL drop independently on its own ready; FSM moves to W_RESP when both have been accepted.
REQ-017 In W_RESP, m_bready SHALL be high; on m_bvalid, bresp SHALL be registered and s_bvalid asserted the next cycle, held until s_bready; then W_IDLE.
REQ-018 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA, R_ERR with the same pattern: s_arready pulses in R_IDLE; m_arvalid asserts the next cycle; rdata/rresp are registered; s_rvalid is held until s_rready.
REQ-019 Minimum latency s_*valid accept -> s_bvalid/s_rvalid SHALL be 3 cycles with a zero-wait slave.
REQ-020 The unselected master's valid outputs SHALL stay 0; m_bready/m_rready SHALL be high only in W_RESP/R_DATA toward the selected master.
REQ-021 Simultaneous read and write to the same or different slaves SHALL proceed concurrently without ordering between them.
REQ-022 s_* payload SHALL be ignored while the matching FSM is not idle; ready stays 0.

Reset
REQ-023 While rst is high, both FSMs SHALL go to idle and every valid/ready output SHALL be 0; data, addr and resp outputs SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction; no response SHALL be issued for it after rst deasserts.

Configuration
REQ-025 Macro AXIL_SPLIT_DECERR_EN defined: an unmapped address SHALL enter W_ERR/R_ERR, issue no master access, and return resp 2'b11 (rdata 0) on the cycle after capture.
REQ-026 AXIL_SPLIT_DECERR_EN undefined: unmapped addresses SHALL route to M0 and W_ERR/R_ERR SHALL not be reachable.

Verification
REQ-027 Write 0x0000_1000, data 0x...DEADBEEF, strb 0xFFFF, zero-wait M0 -> exactly one m0 aw/w handshake, m1 untouched, s_bresp 0, s_bvalid 3 cycles after accept.
REQ-028 Read 0x4000_0010, M1 returns 0x1234 after 5 wait cycles -> s_rdata 0x1234, rresp 0, no m0 activity.
REQ-029 With DECERR_EN, read 0x8000_0000 -> s_rresp 2'b11, s_rdata 0, no master valid ever high; without it -> m0_arvalid with addr 0x8000_0000.
REQ-030 s_awvalid high, s_wvalid low for 4 cycles -> s_awready stays 0 until s_wvalid rises, then both ready in the same cycle.
REQ-031 Concurrent write to M1 and read from M0, s_bready/s_rready held low 3 cycles -> both responses held stable, complete after ready, no new accept meanwhile.
REQ-032 rst asserted while in W_RESP with M0 bvalid pending -> all outputs 0 next cycle; after release, s_bvalid stays 0 until a new write.
